// File: rtl/multi_cycle_ctrl_if.sv
// Control bus between the multi-cycle controller and the datapath.
// master = controller side, slave = datapath side.
interface multi_cycle_ctrl_if #(parameter int OP_W = 4);
  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            mem_ready;
  logic            pc_en;
  logic [1:0]      pc_src;
  logic            ir_write;
  logic            mem_req;
  logic            mem_we;
  logic            mem_addr_sel;
  logic            reg_write;
  logic            wb_sel;
  logic            alu_src;
  logic [2:0]      alu_op;
  logic            illegal_op;
  logic            halted;
  logic [2:0]      state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_en, pc_src, ir_write, mem_req, mem_we, mem_addr_sel,
           reg_write, wb_sel, alu_src, alu_op, illegal_op, halted, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_en, pc_src, ir_write, mem_req, mem_we, mem_addr_sel,
           reg_write, wb_sel, alu_src, alu_op, illegal_op, halted, state
  );
endinterface

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle processor: FETCH/DECODE/EXEC/MEM/WB/HALT.
// Only the state is registered; all control lines decode combinationally.
// Optional macro CTRL_PERF_CNT_EN adds cycle_cnt / instr_cnt performance counters.
module multi_cycle_ctrl #(
  parameter int OP_W  = 4
`ifdef CTRL_PERF_CNT_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic clk,
  input  logic rst,
`ifdef CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
`endif
  multi_cycle_ctrl_if.master bus
);

  localparam logic [OP_W-1:0] OP_ALU  = OP_W'(0);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(1);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(2);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(3);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
  localparam logic [OP_W-1:0] OP_JMP  = OP_W'(5);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'(15);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t state, next;

  assign bus.state = state;

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_FETCH;
    else     state <= next;
  end

  // Next-state and control decode; every output is held low during reset.
  always_comb begin
    next             = S_FETCH;
    bus.pc_en        = 1'b0;
    bus.pc_src       = 2'd0;
    bus.ir_write     = 1'b0;
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.mem_addr_sel = 1'b0;
    bus.reg_write    = 1'b0;
    bus.wb_sel       = 1'b0;
    bus.alu_src      = 1'b0;
    bus.alu_op       = 3'd0;
    bus.illegal_op   = 1'b0;
    bus.halted       = 1'b0;
    case (state)
      S_FETCH: begin
        bus.mem_req = !rst;
        if (bus.mem_ready) begin
          bus.ir_write = !rst;
          bus.pc_en    = !rst;
          next         = S_DECODE;
        end else begin
          next = S_FETCH;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_ALU, OP_ADDI, OP_LW, OP_SW, OP_BEQ: next = S_EXEC;
          OP_JMP: begin
            bus.pc_en  = !rst;
            bus.pc_src = rst ? 2'd0 : 2'd2;
            next       = S_FETCH;
          end
          OP_HALT: next = S_HALT;
          default: begin
            // undefined opcode retires as a NOP
            bus.illegal_op = !rst;
            next           = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        next = S_FETCH;
        if (!rst) begin
          case (bus.opcode)
            OP_ALU: begin
              bus.alu_op = 3'd4;
              next       = S_WB;
            end
            OP_ADDI, OP_LW, OP_SW: begin
              bus.alu_op  = 3'd0;
              bus.alu_src = 1'b1;
              next        = (bus.opcode == OP_ADDI) ? S_WB : S_MEM;
            end
            OP_BEQ: begin
              bus.alu_op = 3'd1;
              if (bus.zero) begin
                bus.pc_en  = 1'b1;
                bus.pc_src = 2'd1;
              end
            end
            default: next = S_FETCH;
          endcase
        end
      end
      S_MEM: begin
        bus.mem_req      = !rst;
        bus.mem_addr_sel = !rst;
        bus.mem_we       = !rst && (bus.opcode == OP_SW);
        if (!bus.mem_ready)            next = S_MEM;
        else if (bus.opcode == OP_LW)  next = S_WB;
        else                           next = S_FETCH;
      end
      S_WB: begin
        bus.reg_write = !rst;
        bus.wb_sel    = !rst && (bus.opcode == OP_LW);
        next          = S_FETCH;
      end
      S_HALT: begin
        bus.halted = !rst;
        next       = S_HALT;
      end
      default: next = S_FETCH;
    endcase
  end

`ifdef CTRL_PERF_CNT_EN
  // Performance counters: cycles spent running, and instructions retired or dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      if (state != S_HALT) cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (next == S_FETCH && (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}))
        instr_cnt <= instr_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Randomized scoreboard bench for multi_cycle_ctrl. Stimulus drives one cycle at a
// time and pushes the expected control vector; a monitor pops and compares.
module tb_multi_cycle_ctrl;
  localparam int OP_W  = 4;
  localparam int CNT_W = 16;
  localparam int N_CYC = 4000;

  localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_WB = 4, P_HALT = 5;

  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       reg_write;
    logic       wb_sel;
    logic       alu_src;
    logic [2:0] alu_op;
    logic       illegal_op;
    logic       halted;
    logic [2:0] state;
  } ctl_t;

  typedef struct {
    ctl_t        ctl;
    int unsigned cyc;
    int unsigned ins;
    int          n;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_cycle_ctrl_if #(.OP_W(OP_W)) bus();

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;
  multi_cycle_ctrl #(.OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .bus(bus.master));
`else
  multi_cycle_ctrl #(.OP_W(OP_W)) dut (.clk(clk), .rst(rst), .bus(bus.master));
`endif

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // reference model: current step of the instruction plus the steps still to run
  int          phase = P_FETCH;
  int          plan[$];
  logic [3:0]  op = 4'd0;
  int unsigned cyc = 0, ins = 0;
  int          halt_cnt = 0;

  function automatic logic [3:0] pick_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 84)      return 4'($urandom_range(0, 5));
    else if (r < 94) return 4'($urandom_range(6, 14));
    else if (r < 97) return 4'd15;
    else             return 4'd0;
  endfunction

  // what the controller must show in a given step of an instruction
  function automatic ctl_t model_out(int ph, logic [3:0] o, logic z, logic mr);
    ctl_t c;
    c = '0;
    c.state = 3'(ph);
    case (ph)
      P_FETCH: begin
        c.mem_req = 1'b1;
        if (mr) begin c.ir_write = 1'b1; c.pc_en = 1'b1; end
      end
      P_DECODE: begin
        if (o == 4'd5) begin c.pc_en = 1'b1; c.pc_src = 2'd2; end
        else if (!(o <= 4'd4 || o == 4'd15)) c.illegal_op = 1'b1;
      end
      P_EXEC: begin
        case (o)
          4'd0: c.alu_op = 3'd4;
          4'd1, 4'd2, 4'd3: c.alu_src = 1'b1;
          4'd4: begin
            c.alu_op = 3'd1;
            if (z) begin c.pc_en = 1'b1; c.pc_src = 2'd1; end
          end
          default: ;
        endcase
      end
      P_MEM: begin
        c.mem_req = 1'b1; c.mem_addr_sel = 1'b1; c.mem_we = (o == 4'd3);
      end
      P_WB: begin
        c.reg_write = 1'b1; c.wb_sel = (o == 4'd2);
      end
      P_HALT: c.halted = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic model_step(logic mr);
    int nxt;
    nxt = P_FETCH;
    case (phase)
      P_FETCH: nxt = mr ? P_DECODE : P_FETCH;
      P_DECODE: begin
        plan.delete();
        case (op)
          4'd0, 4'd1: plan = '{P_EXEC, P_WB};
          4'd2:       plan = '{P_EXEC, P_MEM, P_WB};
          4'd3:       plan = '{P_EXEC, P_MEM};
          4'd4:       plan = '{P_EXEC};
          default: ;
        endcase
        if (op == 4'd15)         nxt = P_HALT;
        else if (plan.size() > 0) nxt = plan.pop_front();
      end
      P_EXEC, P_WB: if (plan.size() > 0) nxt = plan.pop_front();
      P_MEM: begin
        if (!mr)                  nxt = P_MEM;
        else if (plan.size() > 0) nxt = plan.pop_front();
      end
      P_HALT: nxt = P_HALT;
      default: ;
    endcase
    if (phase != P_HALT) cyc++;
    if (nxt == P_FETCH && phase >= P_DECODE && phase <= P_WB) ins++;
    phase = nxt;
  endtask

  // stimulus + expectation
  initial begin
    exp_t e;
    logic do_rst, z, mr;
    bus.opcode = '0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    for (int i = 0; i < N_CYC; i++) begin
      @(negedge clk);
      do_rst = (i < 2) || ($urandom_range(0, 59) == 0) || (halt_cnt >= 20);
      if (phase == P_FETCH) op = pick_op();
      z  = 1'($urandom_range(0, 1));
      mr = ($urandom_range(0, 9) < 7);
      bus.opcode = op; bus.zero = z; bus.mem_ready = mr;
      rst = do_rst;
      e.n = i;
      if (do_rst) begin
        e.ctl = '0; e.cyc = 0; e.ins = 0;
        phase = P_FETCH; plan.delete(); cyc = 0; ins = 0; halt_cnt = 0;
      end else begin
        e.ctl = model_out(phase, op, z, mr);
        e.cyc = cyc; e.ins = ins;
        if (phase == P_HALT) halt_cnt++;
        model_step(mr);
      end
      sb.push_back(e);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // monitor: compare the DUT against each expectation mid-cycle
  initial begin : mon
    exp_t e;
    ctl_t a;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{bus.pc_en, bus.pc_src, bus.ir_write, bus.mem_req, bus.mem_we,
              bus.mem_addr_sel, bus.reg_write, bus.wb_sel, bus.alu_src, bus.alu_op,
              bus.illegal_op, bus.halted, bus.state};
        tests++;
        if (a !== e.ctl) begin
          fails++;
          $display("FAIL ctl cycle %0d: got %h expected %h (state got %0d exp %0d)",
                   e.n, a, e.ctl, a.state, e.ctl.state);
        end
`ifdef CTRL_PERF_CNT_EN
        tests++;
        if (cycle_cnt !== CNT_W'(e.cyc) || instr_cnt !== CNT_W'(e.ins)) begin
          fails++;
          $display("FAIL perf cycle %0d: got cyc=%0d ins=%0d expected cyc=%0d ins=%0d",
                   e.n, cycle_cnt, instr_cnt, e.cyc, e.ins);
        end
`endif
      end
    end
  end

endmodule
